// File: rtl/cra_seq.sv
// cra_seq: microsequencer next-address unit with subroutine stack (CRA_STACK_TRAP_EN vectors stack faults to TRAP_ADDR)
module cra_seq #(
  parameter int ADDR_W = 12,
  parameter int STACK_DEPTH = 16,
  parameter int NCOND = 64,
  parameter int DRAMJ_W = 10,
  parameter logic [ADDR_W-1:0] FORCE_ADDR = 12'o1777,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = 12'o0017
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         advance,
  input  logic                         force1777,
  input  logic [ADDR_W-1:0]            J,
  input  logic [$clog2(NCOND)-1:0]     SKIP,
  input  logic [NCOND-1:0]             condIn,
  input  logic [4:0]                   DISP,
  input  logic                         CALL,
  input  logic [DRAMJ_W-1:0]           DRAM_J,
  input  logic [2:0]                   DRAM_A,
  input  logic [2:0]                   DRAM_B,
  input  logic [3:0]                   dispIn,
  input  logic                         MULdone,
  output logic [ADDR_W-1:0]            CRADR,
  output logic [$clog2(STACK_DEPTH):0] stackLevel,
  output logic                         stackOvf,
  output logic                         stackUnf
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(STACK_DEPTH);
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [PW-1:0] sp, sp_pop, sp_nxt;
  logic [PW:0] lvl_pop, lvl_nxt;
  logic [ADDR_W-1:0] pop_val, base, calc, nxt;
  logic hold, act, do_pop, do_push, unf, ovf, skip;
  always_comb begin
    hold = DISP == 5'd6 && !MULdone;
    act = advance && !force1777 && !hold;
    do_pop = act && DISP == 5'd1;
    do_push = act && CALL;
    unf = do_pop && stackLevel == '0;
    pop_val = stackLevel == '0 ? '0 : stack[sp - 1'b1];
    lvl_pop = do_pop && !unf ? stackLevel - 1'b1 : stackLevel;
    sp_pop = do_pop && !unf ? sp - 1'b1 : sp;
    ovf = do_push && lvl_pop == FULL;
    lvl_nxt = do_push && !ovf ? lvl_pop + 1'b1 : lvl_pop;
    sp_nxt = do_push ? sp_pop + 1'b1 : sp_pop;
    base = DISP == 5'd1 ? pop_val | ADDR_W'(J[3:0])
         : DISP == 5'd2 ? ADDR_W'(DRAM_J)
         : DISP == 5'd3 ? J | ADDR_W'(DRAM_A)
         : DISP == 5'd4 ? J | ADDR_W'(DRAM_B)
         : DISP == 5'd5 ? J | ADDR_W'(dispIn)
         : hold ? CRADR : J;
    skip = !hold && SKIP != '0 && condIn[SKIP];
    calc = skip ? base | ADDR_W'(1) : base;
`ifdef CRA_STACK_TRAP_EN
    nxt = force1777 ? FORCE_ADDR : (ovf || unf) ? TRAP_ADDR : calc;
`else
    nxt = force1777 ? FORCE_ADDR : calc;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      CRADR <= '0;
      sp <= '0;
      stackLevel <= '0;
      stackOvf <= 1'b0;
      stackUnf <= 1'b0;
    end else if (advance) begin
      CRADR <= nxt;
      sp <= sp_nxt;
      stackLevel <= lvl_nxt;
      stackOvf <= stackOvf | ovf;
      stackUnf <= stackUnf | unf;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && do_push) stack[sp_pop] <= CRADR;
  end
endmodule

// File: tb/tb_cra_seq.sv
// tb_cra_seq: directed bench for cra_seq with a queue-based reference model
module tb_cra_seq;
  logic clk = 0, reset = 1, advance = 0, force1777 = 0, CALL = 0, MULdone = 0;
  logic [11:0] J = 0;
  logic [5:0] SKIP = 0;
  logic [63:0] condIn = 0;
  logic [4:0] DISP = 0;
  logic [9:0] DRAM_J = 0;
  logic [2:0] DRAM_A = 0, DRAM_B = 0;
  logic [3:0] dispIn = 0;
  logic [11:0] CRADR;
  logic [4:0] stackLevel;
  logic stackOvf, stackUnf;
  int nvec = 0, nfail = 0;
  bit chk_en = 0;
  logic [11:0] q[$];
  logic [11:0] m_cradr = 0;
  bit m_ovf = 0, m_unf = 0;
  always #5 clk = ~clk;
  cra_seq dut (
    .clk(clk), .reset(reset), .advance(advance), .force1777(force1777), .J(J),
    .SKIP(SKIP), .condIn(condIn), .DISP(DISP), .CALL(CALL), .DRAM_J(DRAM_J),
    .DRAM_A(DRAM_A), .DRAM_B(DRAM_B), .dispIn(dispIn), .MULdone(MULdone),
    .CRADR(CRADR), .stackLevel(stackLevel), .stackOvf(stackOvf), .stackUnf(stackUnf)
  );
  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask
  task automatic lit(string name, int act, int model, int exp);
    chk(name, act, exp);
    chk({name, "_model"}, model, exp);
  endtask
  task automatic model_step();
    logic [11:0] tgt, pv;
    bit f;
    f = 0;
    if (force1777) begin
      m_cradr = 12'o1777;
      return;
    end
    if (DISP == 6 && !MULdone) return;
    case (DISP)
      1: begin
        if (q.size() == 0) begin pv = 0; m_unf = 1; f = 1; end
        else pv = q.pop_back();
        tgt = pv | {8'b0, J[3:0]};
      end
      2: tgt = {2'b0, DRAM_J};
      3: tgt = J | {9'b0, DRAM_A};
      4: tgt = J | {9'b0, DRAM_B};
      5: tgt = J | {8'b0, dispIn};
      default: tgt = J;
    endcase
    if (CALL) begin
      if (q.size() == 16) begin void'(q.pop_front()); m_ovf = 1; f = 1; end
      q.push_back(m_cradr);
    end
    if (SKIP != 0 && condIn[SKIP]) tgt[0] = 1'b1;
`ifdef CRA_STACK_TRAP_EN
    if (f) tgt = 12'o0017;
`endif
    m_cradr = tgt;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_cradr = 0;
      m_ovf = 0;
      m_unf = 0;
    end else if (advance) model_step();
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cradr", CRADR, m_cradr);
      chk("level", stackLevel, q.size());
      chk("ovf", stackOvf, m_ovf);
      chk("unf", stackUnf, m_unf);
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    chk_en = 1;
    lit("rst_cradr", CRADR, m_cradr, 0);
    lit("rst_level", stackLevel, q.size(), 0);
    advance = 1; J = 12'o100; tick();
    lit("t1_cradr", CRADR, m_cradr, 'o100);
    lit("t1_level", stackLevel, q.size(), 0);
    J = 12'o200; SKIP = 5; condIn[5] = 1; tick();
    lit("skip_on", CRADR, m_cradr, 'o201);
    condIn[5] = 0; tick();
    lit("skip_off", CRADR, m_cradr, 'o200);
    advance = 0; J = 12'o777; CALL = 1; DISP = 1; tick();
    lit("hold", CRADR, m_cradr, 'o200);
    lit("hold_level", stackLevel, q.size(), 0);
    advance = 1; CALL = 0; DISP = 0; SKIP = 0; J = 12'o300; tick();
    CALL = 1; J = 12'o400; tick();
    lit("call", CRADR, m_cradr, 'o400);
    lit("call_level", stackLevel, q.size(), 1);
    CALL = 0; DISP = 1; J = 12'o002; tick();
    lit("ret", CRADR, m_cradr, 'o302);
    lit("ret_level", stackLevel, q.size(), 0);
    DISP = 0; CALL = 1;
    for (int i = 0; i < 17; i++) begin
      J = 12'('o1000 + 16 * i);
      tick();
    end
    lit("full_level", stackLevel, q.size(), 16);
    lit("ovf_set", stackOvf, m_ovf, 1);
    lit("unf_clear", stackUnf, m_unf, 0);
    CALL = 0; DISP = 1; J = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) lit("pop_first", CRADR, m_cradr, 'o1360);
      if (i == 15) lit("pop_16th", CRADR, m_cradr, 'o1000);
    end
    lit("empty_level", stackLevel, q.size(), 0);
    lit("unf_set", stackUnf, m_unf, 1);
    DISP = 0; J = 12'o444; tick();
    DISP = 6; MULdone = 0; CALL = 1; J = 12'o555; SKIP = 5; condIn[5] = 1;
    repeat (3) tick();
    lit("mul_hold", CRADR, m_cradr, 'o444);
    lit("mul_level", stackLevel, q.size(), 0);
    MULdone = 1; CALL = 0; SKIP = 0; condIn[5] = 0; J = 12'o500; tick();
    lit("mul_done", CRADR, m_cradr, 'o500);
    DISP = 2; DRAM_J = 10'o1234; tick();
    lit("dramj", CRADR, m_cradr, 'o1234);
    DISP = 3; J = 12'o700; DRAM_A = 5; tick();
    lit("disp_a", CRADR, m_cradr, 'o705);
    DISP = 4; DRAM_B = 3; tick();
    lit("disp_b", CRADR, m_cradr, 'o703);
    DISP = 5; dispIn = 4'b1010; tick();
    lit("disp_ext", CRADR, m_cradr, 'o712);
    DISP = 3; DRAM_A = 1; SKIP = 5; condIn[5] = 1; tick();
    lit("skip_nocarry", CRADR, m_cradr, 'o701);
    SKIP = 0; DISP = 7; J = 12'o123; tick();
    lit("disp7", CRADR, m_cradr, 'o123);
    DISP = 31; J = 12'o321; tick();
    lit("disp31", CRADR, m_cradr, 'o321);
    DISP = 0; CALL = 1; J = 12'o600; tick();
    lit("pre_force_level", stackLevel, q.size(), 1);
    force1777 = 1; DISP = 1; tick();
    lit("force", CRADR, m_cradr, 'o1777);
    lit("force_level", stackLevel, q.size(), 1);
    force1777 = 0; CALL = 0; DISP = 0; reset = 1; tick();
    lit("mid_rst_cradr", CRADR, m_cradr, 0);
    lit("mid_rst_level", stackLevel, q.size(), 0);
    lit("mid_rst_ovf", stackOvf, m_ovf, 0);
    lit("mid_rst_unf", stackUnf, m_unf, 0);
    reset = 0; J = 12'o42; tick();
    lit("post_rst", CRADR, m_cradr, 'o42);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
